alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle control sequencer for the single-ALU 8-bit core. It fetches 9-bit instructions over a request/acknowledge port and holds the decoded fields steady for the ALU and register file. It captures the ALU result, performs register write-back and owns the 9-bit program counter. It sits between instruction memory, the register file and the ALU, and is the only block that advances PC.

## Interface
- RESET_PC, 9'h000, PC value loaded at reset and on START.
- FETCH_TIMEOUT, 15, maximum cycles FETCH waits for IMEM_ACK before FAULT.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low.
- START  in  1  single-cycle pulse; leaves IDLE, HALT or FAULT and restarts from RESET_PC.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  9  fetch address, equals PC.
- IMEM_ACK  in  1  fetch data valid this cycle.
- IMEM_DATA  in  9  instruction: [8:4] opcode, [3:2] flag/reg2, [1:0] reg1.
- OPCODE  out  5  registered IR[8:4] to ALU.
- FLAG_REG2  out  2  registered IR[3:2].
- REG1  out  2  registered IR[1:0].
- ALU_DATA  in  8  ALU DATA_OUT.
- ALU_REGTARGET  in  3  ALU REGTARGET.
- ALU_PCOUT  in  9  ALU PCOUT.
- RF_WE  out  1  register-file write strobe, one cycle.
- RF_WADDR  out  3  write address.
- RF_WDATA  out  8  write data.
- PC  out  9  current program counter.
- BUSY  out  1  high in FETCH/DECODE/EXEC/WB.
- HALTED  out  1  high in HALT.
- FAULT  out  1  high in FAULT.
- INSTR_CNT  out  16  retired-instruction count, saturating at 16'hFFFF.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT, FAULT.
- Reset state is IDLE. Outputs at reset: PC=RESET_PC. INSTR_CNT, OPCODE, FLAG_REG2, REG1, RF_* and IMEM_REQ are 0. BUSY, HALTED and FAULT are 0.
- IDLE/HALT/FAULT + START -> FETCH. START also sets PC=RESET_PC and clears INSTR_CNT. START in any other state is ignored.
- FETCH:
  - IMEM_REQ=1 with IMEM_ADDR=PC, held stable until IMEM_ACK is sampled high.
  - On ACK: IR<=IMEM_DATA, go to DECODE.
  - Wait counter counts cycles without ACK. When it reaches FETCH_TIMEOUT: go to FAULT with IMEM_REQ dropped.
- DECODE: IR fields are driven; register-file reads settle. Next state is EXEC. If the opcode is kHLT, go to HALT instead; PC does not change and INSTR_CNT increments.
- EXEC: ALU_DATA, ALU_REGTARGET and ALU_PCOUT are registered into result holding regs.
- WB:
  - Writing opcodes are kADD, kSHF, kMOV, kFIL, kCMP, kAND and kNEG. For these: RF_WE=1, RF_WADDR=captured REGTARGET, RF_WDATA=captured data.
  - Next PC:
    - kBRH: captured ALU_PCOUT if captured data==8'h01, else PC+1.
    - kJUM with FLAG_REG2==kONE: captured ALU_PCOUT.
    - All other cases: PC+1.
  - PC arithmetic is mod 512 (9'h1FF+1 -> 9'h000).
  - INSTR_CNT increments (saturating). Next state is FETCH.
- Unknown opcodes retire as no-ops (PC+1, no write).

## Timing
- Non-halting instruction: 4 cycles + (ACK wait cycles). With ACK in the first FETCH cycle, the next IMEM_REQ rises exactly 4 cycles after the previous one.
- RF_WE is high for exactly one cycle, the WB cycle. The new PC is visible the cycle after WB.
- IMEM_DATA is ignored when IMEM_ACK is 0. An ACK outside FETCH is ignored.
- RST_N assertion in any state forces reset values immediately (asynchronous). An in-flight write or fetch is abandoned. Release is synchronous to CLK.
- Timeout boundary: an ACK arriving on the same cycle the counter reaches FETCH_TIMEOUT wins, and the fetch completes.

## Structure
- Add the state enum (seq_state_t), the kHLT opcode constant and instruction-field widths to the shared definitions package. Reuse the existing opcode and flag constants (kADD…kJUM, kZER/kONS/kONE/kSEV).
- One sub-module: seq_fetch_timer, the FETCH wait counter with a clear/enable interface and a timeout flag output.

## Test plan
- Reset, START, IMEM_DATA={kFIL,kONS,2'b01} with ACK in 1 cycle -> RF_WE in WB with WADDR=3'b001, WDATA=8'hFF; PC 0->1; INSTR_CNT=1.
- kBRH with ALU_DATA=8'h01, ALU_PCOUT=9'h040 at PC=9'h010 -> PC=9'h040, no RF_WE; repeat with ALU_DATA=0 -> PC=9'h011.
- PC=9'h1FF, kMOV -> PC wraps to 9'h000 after WB.
- Hold IMEM_ACK low for FETCH_TIMEOUT cycles -> FAULT=1, IMEM_REQ=0. START -> FETCH from RESET_PC. ACK on the timeout cycle -> no fault.
- kHLT fetched -> HALTED=1, PC unchanged, no further IMEM_REQ. START restarts at RESET_PC with INSTR_CNT=0.
- Assert RST_N low during WB -> RF_WE drops without waiting for a clock edge; all outputs at reset values; state IDLE.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the single-ALU 8-bit core sequencer.
// This file holds the opcode and flag encodings, the field widths and the sequencer state type.
package alu_sequencer_pkg;

  localparam int INSTR_W  = 9;
  localparam int OPCODE_W = 5;
  localparam int FIELD_W  = 2;
  localparam int PC_W     = 9;
  localparam int DATA_W   = 8;
  localparam int REGT_W   = 3;
  localparam int CNT_W    = 16;

  localparam logic [PC_W-1:0] SEQ_RESET_PC      = 9'h000;
  localparam int              SEQ_FETCH_TIMEOUT = 15;

  localparam logic [OPCODE_W-1:0] kADD = 5'h00;
  localparam logic [OPCODE_W-1:0] kSHF = 5'h01;
  localparam logic [OPCODE_W-1:0] kMOV = 5'h02;
  localparam logic [OPCODE_W-1:0] kFIL = 5'h03;
  localparam logic [OPCODE_W-1:0] kCMP = 5'h04;
  localparam logic [OPCODE_W-1:0] kAND = 5'h05;
  localparam logic [OPCODE_W-1:0] kNEG = 5'h06;
  localparam logic [OPCODE_W-1:0] kBRH = 5'h07;
  localparam logic [OPCODE_W-1:0] kJUM = 5'h08;
  localparam logic [OPCODE_W-1:0] kHLT = 5'h1F;

  localparam logic [FIELD_W-1:0] kZER = 2'b00;
  localparam logic [FIELD_W-1:0] kONS = 2'b01;
  localparam logic [FIELD_W-1:0] kONE = 2'b10;
  localparam logic [FIELD_W-1:0] kSEV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_FAULT
  } seq_state_t;

  function automatic logic is_writing_op(input logic [OPCODE_W-1:0] op);
    return op inside {kADD, kSHF, kMOV, kFIL, kCMP, kAND, kNEG};
  endfunction

endpackage

// File: rtl/alu_sequencer_seq_fetch_timer.sv
// FETCH wait timer: a down-counter that reloads on clr and steps on en.
// It reaches terminal count after TIMEOUT-1 steps, so the TIMEOUT-th unacknowledged cycle raises timeout.
module seq_fetch_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign timeout = (cnt == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/exec/write-back sequencer for the single-ALU core.
// This block owns PC, the instruction register, the ALU result capture and the retired-instruction count.
//
// state    | meaning
// IDLE     | after reset, waiting for start
// FETCH    | imem_req high, waiting for imem_ack (bounded)
// DECODE   | IR fields driven, register-file reads settle
// EXEC     | ALU outputs captured
// WB       | register write strobe, PC update, retire
// HALT     | kHLT retired, waiting for start
// FAULT    | fetch timed out, waiting for start
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC      = SEQ_RESET_PC,
  parameter int              FETCH_TIMEOUT = SEQ_FETCH_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_data,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FIELD_W-1:0]  flag_reg2,
  output logic [FIELD_W-1:0]  reg1,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic [REGT_W-1:0]   alu_regtarget,
  input  logic [PC_W-1:0]     alu_pcout,
  output logic                rf_we,
  output logic [REGT_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [PC_W-1:0]     pc,
  output logic                busy,
  output logic                halted,
  output logic                fault,
  output logic [CNT_W-1:0]    instr_cnt
);

  seq_state_t state, state_nxt;

  logic [DATA_W-1:0] cap_data;
  logic [REGT_W-1:0] cap_target;
  logic [PC_W-1:0]   cap_pcout;
  logic [PC_W-1:0]   pc_nxt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timed_out;
  logic              in_fetch;

  assign in_fetch  = (state == S_FETCH);
  assign imem_addr = pc;
  assign cnt_inc   = (instr_cnt == '1) ? instr_cnt : instr_cnt + 1'b1;

  seq_fetch_timer #(
    .TIMEOUT (FETCH_TIMEOUT)
  ) u_fetch_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!in_fetch),
    .en      (in_fetch && !imem_ack),
    .timeout (timed_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    pc_nxt    = pc + 1'b1;
    if ((opcode == kBRH) && (cap_data == 8'h01)) begin
      pc_nxt = cap_pcout;
    end else if ((opcode == kJUM) && (flag_reg2 == kONE)) begin
      pc_nxt = cap_pcout;
    end

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        // ACK takes priority over the timeout on the same cycle
        if (imem_ack) begin
          state_nxt = S_DECODE;
        end else if (timed_out) begin
          state_nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        busy      = 1'b1;
        state_nxt = (opcode == kHLT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        busy      = 1'b1;
        state_nxt = S_WB;
      end
      S_WB: begin
        busy = 1'b1;
        if (is_writing_op(opcode)) begin
          rf_we    = 1'b1;
          rf_waddr = cap_target;
          rf_wdata = cap_data;
        end
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) state_nxt = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
        if (start) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      instr_cnt  <= '0;
      opcode     <= '0;
      flag_reg2  <= '0;
      reg1       <= '0;
      cap_data   <= '0;
      cap_target <= '0;
      cap_pcout  <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT, S_FAULT: begin
          if (start) begin
            pc        <= RESET_PC;
            instr_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            {opcode, flag_reg2, reg1} <= imem_data;
          end
        end
        S_DECODE: begin
          if (opcode == kHLT) instr_cnt <= cnt_inc;
        end
        S_EXEC: begin
          cap_data   <= alu_data;
          cap_target <= alu_regtarget;
          cap_pcout  <= alu_pcout;
        end
        S_WB: begin
          pc        <= pc_nxt;
          instr_cnt <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a table of instructions with expected write-back and next PC,
// a write scoreboard queue, and hand-written timeout, halt and reset-during-write-back sequences.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_ack;
  logic [8:0]  imem_data;
  logic [4:0]  opcode;
  logic [1:0]  flag_reg2;
  logic [1:0]  reg1;
  logic [7:0]  alu_data;
  logic [2:0]  alu_regtarget;
  logic [8:0]  alu_pcout;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic [8:0]  pc;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [15:0] instr_cnt;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .opcode        (opcode),
    .flag_reg2     (flag_reg2),
    .reg1          (reg1),
    .alu_data      (alu_data),
    .alu_regtarget (alu_regtarget),
    .alu_pcout     (alu_pcout),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .pc            (pc),
    .busy          (busy),
    .halted        (halted),
    .fault         (fault),
    .instr_cnt     (instr_cnt)
  );

  typedef struct {
    logic [8:0] instr;
    logic [7:0] data;
    logic [2:0] tgt;
    logic [8:0] pcout;
    int         ack_wait;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [8:0] pc_next;
  } vec_t;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  localparam int NVEC = 11;
  vec_t  vecs[NVEC];
  wr_t   wq[$];
  wr_t   exp_wr;
  int    errors = 0;
  int    checks = 0;
  logic [8:0]  exp_pc;
  logic [15:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(imem_req), 32'd1);
  endtask

  // Acts as instruction memory and ALU for one instruction; returns at the DECODE-cycle negedge.
  task automatic fetch_one(input logic [8:0] instr, input int wait_n,
                           input logic [7:0] d, input logic [2:0] t, input logic [8:0] pco);
    wait_req();
    chk("fetch_addr", 32'(imem_addr), 32'(exp_pc));
    chk("instr_cnt", 32'(instr_cnt), 32'(exp_cnt));
    for (int i = 0; i < wait_n; i++) begin
      imem_data = 9'($urandom);
      @(negedge clk);
    end
    chk("req_held", 32'({imem_req, imem_addr}), 32'({1'b1, exp_pc}));
    imem_ack      = 1'b1;
    imem_data     = instr;
    alu_data      = d;
    alu_regtarget = t;
    alu_pcout     = pco;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 9'($urandom);
    chk("ir_fields", 32'({opcode, flag_reg2, reg1}), 32'(instr));
  endtask

  // Write scoreboard: every RF_WE cycle must match the oldest pending expected write.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && rf_we) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rf_write_unexpected actual=%0h/%0h required=none", rf_waddr, rf_wdata);
        end else begin
          exp_wr = wq.pop_front();
          chk("rf_write", 32'({rf_waddr, rf_wdata}), 32'(exp_wr));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  saw_req;

    vecs[0]  = '{{kFIL, kONS, 2'b01}, 8'hFF, 3'd1, 9'h000, 0, 1'b1, 3'd1, 8'hFF, 9'h001};
    vecs[1]  = '{{kJUM, kONE, 2'b00}, 8'h00, 3'd0, 9'h010, 1, 1'b0, 3'd0, 8'h00, 9'h010};
    vecs[2]  = '{{kBRH, kZER, 2'b00}, 8'h01, 3'd0, 9'h040, 0, 1'b0, 3'd0, 8'h00, 9'h040};
    vecs[3]  = '{{kJUM, kONE, 2'b11}, 8'h00, 3'd0, 9'h010, 2, 1'b0, 3'd0, 8'h00, 9'h010};
    vecs[4]  = '{{kBRH, kZER, 2'b00}, 8'h00, 3'd0, 9'h040, 0, 1'b0, 3'd0, 8'h00, 9'h011};
    vecs[5]  = '{{kADD, kZER, 2'b10}, 8'h5A, 3'd3, 9'h0AA, 3, 1'b1, 3'd3, 8'h5A, 9'h012};
    vecs[6]  = '{{kJUM, kZER, 2'b00}, 8'h00, 3'd0, 9'h100, 0, 1'b0, 3'd0, 8'h00, 9'h013};
    vecs[7]  = '{{5'h15, kSEV, 2'b11}, 8'h77, 3'd4, 9'h0F0, 1, 1'b0, 3'd0, 8'h00, 9'h014};
    vecs[8]  = '{{kJUM, kONE, 2'b01}, 8'h00, 3'd0, 9'h1FF, 0, 1'b0, 3'd0, 8'h00, 9'h1FF};
    vecs[9]  = '{{kMOV, kONS, 2'b10}, 8'h33, 3'd7, 9'h055, 0, 1'b1, 3'd7, 8'h33, 9'h000};
    vecs[10] = '{{kNEG, kSEV, 2'b01}, 8'h80, 3'd2, 9'h1F0, 5, 1'b1, 3'd2, 8'h80, 9'h001};

    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = '0;
    alu_data = '0; alu_regtarget = '0; alu_pcout = '0;
    repeat (3) @(negedge clk);

    chk("rst_pc", 32'(pc), 32'h000);
    chk("rst_outputs", 32'({imem_req, busy, halted, fault, rf_we}), 32'd0);
    chk("rst_ir", 32'({opcode, flag_reg2, reg1}), 32'd0);
    chk("rst_rf", 32'({rf_waddr, rf_wdata}), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    imem_ack  = 1'b1;
    imem_data = {kADD, kONE, 2'b11};
    repeat (2) @(negedge clk);
    imem_ack = 1'b0;
    chk("idle_ack_ignored", 32'({busy, opcode, flag_reg2, reg1}), 32'd0);

    pulse_start();
    exp_pc  = 9'h000;
    exp_cnt = 16'd0;
    for (int i = 0; i < NVEC; i++) begin
      if (i == 6) pulse_start();
      if (vecs[i].we) wq.push_back({vecs[i].waddr, vecs[i].wdata});
      fetch_one(vecs[i].instr, vecs[i].ack_wait, vecs[i].data, vecs[i].tgt, vecs[i].pcout);
      exp_cnt++;
      exp_pc = vecs[i].pc_next;
    end

    fetch_one({kHLT, kZER, 2'b00}, 0, 8'h00, 3'd0, 9'h0AB);
    @(negedge clk);
    chk("halt_flags", 32'({halted, busy, fault}), 32'b100);
    chk("halt_pc", 32'(pc), 32'(exp_pc));
    chk("halt_cnt", 32'(instr_cnt), 32'(exp_cnt + 16'd1));
    saw_req = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw_req |= imem_req;
    end
    chk("halt_no_req", 32'(saw_req), 32'd0);

    pulse_start();
    exp_pc  = 9'h000;
    exp_cnt = 16'd0;
    wait_req();
    chk("restart_addr", 32'(imem_addr), 32'h000);
    chk("restart_cnt", 32'(instr_cnt), 32'd0);
    repeat (14) @(negedge clk);
    chk("pre_timeout", 32'({fault, imem_req}), 32'b01);
    @(negedge clk);
    chk("timeout_fault", 32'({fault, imem_req, busy}), 32'b100);

    pulse_start();
    wq.push_back({3'd6, 8'hA5});
    fetch_one({kCMP, kONS, 2'b10}, 14, 8'hA5, 3'd6, 9'h000);
    chk("ack_on_timeout", 32'({fault, busy}), 32'b01);
    exp_pc  = 9'h001;
    exp_cnt = 16'd1;

    wq.push_back({3'd5, 8'hC3});
    fetch_one({kAND, kZER, 2'b01}, 0, 8'hC3, 3'd5, 9'h000);
    n = 0;
    while (!rf_we && n < 20) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk("wb_reached", 32'(rf_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_wb_we", 32'(rf_we), 32'd0);
    chk("rst_wb_outputs", 32'({imem_req, busy, halted, fault, rf_waddr, rf_wdata}), 32'd0);
    chk("rst_wb_state", 32'({pc, instr_cnt, opcode, flag_reg2, reg1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'({busy, imem_req, rf_we}), 32'd0);
    chk("wq_drained", 32'(wq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
